mem_stage_hs: RTL and testbench
===============================

Name: mem_stage_hs

Overview:
- Memory-access stage of the 5-stage pipelined CPU; sits between the execute stage and wb_stage.
- Holds the EXE/MEM pipeline register and drives a request/acknowledge data-memory port with variable wait states.
- Raises mem_stall to the hazard unit while an access is outstanding.
- Presents a bubble (mem_wreg=0) to the downstream MEM/WB register during stall cycles, because that register has no enable.

Parameters:
- AW, 32, data-memory address width (driven from alu result bits [AW-1:0])
- DW, 32, data width

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- exe_wreg  in  1  instruction writes the register file
- exe_m2reg  in  1  instruction is a load
- exe_wmem  in  1  instruction is a store
- exe_aluR  in  DW  ALU result / effective address
- exe_rb  in  DW  store data
- exe_destR  in  5  destination register
- EXE_ins_type  in  4  debug instruction type tag
- EXE_ins_number  in  4  debug instruction sequence tag
- dmem_rdata  in  DW  memory read data
- dmem_ack  in  1  memory completes the current request this cycle
- dmem_req  out  1  access request
- dmem_we  out  1  write enable (store)
- dmem_addr  out  AW  access address
- dmem_wdata  out  DW  store data
- mem_wreg  out  1  to wb_stage; gated by stall
- mem_m2reg  out  1  to wb_stage
- mem_aluR  out  DW  to wb_stage
- mem_mdata  out  DW  load data to wb_stage
- mem_destR  out  5  to wb_stage and forwarding unit
- MEM_ins_type  out  4  debug tag
- MEM_ins_number  out  4  debug tag
- mem_stall  out  1  freeze PC/IF/ID/EXE and this stage's input register

Behaviour:
- Reset, asynchronous and active-low:
  - All register bits go to 0 and the FSM goes to IDLE.
  - All outputs are 0 and dmem_req=0 while rst_n=0.
  - Reset asserted mid-access abandons the request; the memory must tolerate a dropped req.
- EXE/MEM register: loads all exe_* inputs on a rising clk edge when mem_stall=0; holds them when mem_stall=1.
- memop = r_m2reg | r_wmem. If both are set (never produced by the decoder), the access is a store and mem_mdata is don't-care.
- Memory-port outputs:
  - dmem_addr = r_aluR[AW-1:0]
  - dmem_wdata = r_rb
  - dmem_we = r_wmem & dmem_req
  - All three are stable for the whole request.
- FSM states are IDLE, BUSY and DONE:
  - IDLE: dmem_req = memop. If memop & dmem_ack, the zero-wait access completes, mem_stall=0 and the FSM stays in IDLE. If memop & ~dmem_ack, mem_stall=1 and the FSM goes to BUSY. If ~memop, there is no request and no stall.
  - BUSY: dmem_req=1 and mem_stall=1. On dmem_ack, capture dmem_rdata into rdata_q and go to DONE; otherwise stay in BUSY.
  - DONE: dmem_req=0, mem_stall=0 and the results are presented. Next state is IDLE; the register loads the next instruction at this edge.
- Stall timing: ack w cycles after the first req (w>=1) gives w+1 stall cycles; the instruction reaches WB w+1 cycles later than in the zero-wait case.
- mem_mdata = rdata_q in DONE, otherwise dmem_rdata (zero-wait path).
- Bubble gating:
  - mem_wreg = r_wreg & ~mem_stall
  - mem_m2reg = r_m2reg & ~mem_stall
  - Other data outputs pass r_* unchanged.
- dmem_ack is ignored when dmem_req=0.
- There is no timeout; a missing ack stalls the pipeline indefinitely.
- Back-to-back memory ops: DONE -> IDLE, and the new request is issued the cycle after DONE.

Decomposition:
- Shared package cpu_pkg:
  - FSM state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2)
  - ins_type code constants
  - register-index width 5
- One sub-module, reg_exe_mem: the enable-gated, async-reset EXE/MEM register.
- The FSM and output muxing stay in the top module.

Test Plan:
- Reset mid-BUSY: a load is waiting and rst_n is pulled low. Same cycle: dmem_req=0, mem_stall=0, all outputs 0. After release, the FSM is in IDLE.
- Zero-wait load: exe_m2reg=1, exe_wreg=1, exe_aluR=0x40, exe_destR=5, memory acks the same cycle with 0xDEADBEEF. Next cycle: dmem_req=1, dmem_addr=0x40, mem_stall=0, mem_wreg=1, mem_mdata=0xDEADBEEF, mem_destR=5.
- 2-wait-state load: ack on the 3rd req cycle with 0x1234. mem_stall=1 for 3 cycles with mem_wreg=0, then DONE cycle with mem_wreg=1, mem_mdata=0x1234. EXE inputs changed during the stall are not captured.
- Store: exe_wmem=1, exe_aluR=0x80, exe_rb=0xCAFE, ack after 1 wait. Memory sees dmem_we=1, addr=0x80, wdata=0xCAFE held for 2 cycles. mem_wreg stays 0 throughout.
- ALU op after a delayed load: the ALU op reaches the register only after DONE. dmem_req=0, mem_wreg=1, mem_aluR passes through, and no spurious stall occurs.
- Spurious ack while idle: dmem_ack=1 with no memop. No state change and mem_stall=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU pipeline: the memory-stage FSM encoding,
// the debug instruction-type tags and the register-index width.
package cpu_pkg;

  // Register-file index width
  localparam int REG_IDX_W = 5;

  // Memory-stage handshake FSM encoding (plain constants for legacy tools)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Debug instruction-type tags carried alongside each instruction
  localparam logic [3:0] INS_NOP    = 4'd0;
  localparam logic [3:0] INS_ALU    = 4'd1;
  localparam logic [3:0] INS_LOAD   = 4'd2;
  localparam logic [3:0] INS_STORE  = 4'd3;
  localparam logic [3:0] INS_BRANCH = 4'd4;
  localparam logic [3:0] INS_JUMP   = 4'd5;

endpackage

// File: rtl/reg_exe_mem.sv
// EXE/MEM pipeline register. Loads on every rising edge while en=1 and
// holds its contents while the memory stage is stalled (en=0).
module reg_exe_mem
  import cpu_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 exe_wreg,
  input  logic                 exe_m2reg,
  input  logic                 exe_wmem,
  input  logic [DW-1:0]        exe_aluR,
  input  logic [DW-1:0]        exe_rb,
  input  logic [REG_IDX_W-1:0] exe_destR,
  input  logic [3:0]           exe_ins_type,
  input  logic [3:0]           exe_ins_number,
  output logic                 r_wreg,
  output logic                 r_m2reg,
  output logic                 r_wmem,
  output logic [DW-1:0]        r_aluR,
  output logic [DW-1:0]        r_rb,
  output logic [REG_IDX_W-1:0] r_destR,
  output logic [3:0]           r_ins_type,
  output logic [3:0]           r_ins_number
);

  // Capture the execute-stage outputs unless the stage is frozen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wreg       <= 1'b0;
      r_m2reg      <= 1'b0;
      r_wmem       <= 1'b0;
      r_aluR       <= '0;
      r_rb         <= '0;
      r_destR      <= '0;
      r_ins_type   <= '0;
      r_ins_number <= '0;
    end else if (en) begin
      r_wreg       <= exe_wreg;
      r_m2reg      <= exe_m2reg;
      r_wmem       <= exe_wmem;
      r_aluR       <= exe_aluR;
      r_rb         <= exe_rb;
      r_destR      <= exe_destR;
      r_ins_type   <= exe_ins_type;
      r_ins_number <= exe_ins_number;
    end
  end

endmodule

// File: rtl/mem_stage_hs.sv
// Memory-access stage with a req/ack data-memory port. Zero-wait accesses
// complete in the request cycle; slower ones stall the pipeline through
// BUSY and present the captured result for one DONE cycle. During stall
// cycles the write-back controls are forced low so the enable-less MEM/WB
// register downstream sees a bubble.
module mem_stage_hs
  import cpu_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 exe_wreg,
  input  logic                 exe_m2reg,
  input  logic                 exe_wmem,
  input  logic [DW-1:0]        exe_aluR,
  input  logic [DW-1:0]        exe_rb,
  input  logic [REG_IDX_W-1:0] exe_destR,
  input  logic [3:0]           EXE_ins_type,
  input  logic [3:0]           EXE_ins_number,
  input  logic [DW-1:0]        dmem_rdata,
  input  logic                 dmem_ack,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [AW-1:0]        dmem_addr,
  output logic [DW-1:0]        dmem_wdata,
  output logic                 mem_wreg,
  output logic                 mem_m2reg,
  output logic [DW-1:0]        mem_aluR,
  output logic [DW-1:0]        mem_mdata,
  output logic [REG_IDX_W-1:0] mem_destR,
  output logic [3:0]           MEM_ins_type,
  output logic [3:0]           MEM_ins_number,
  output logic                 mem_stall
);

  logic                 r_wreg;
  logic                 r_m2reg;
  logic                 r_wmem;
  logic [DW-1:0]        r_aluR;
  logic [DW-1:0]        r_rb;
  logic [REG_IDX_W-1:0] r_destR;
  logic [3:0]           r_ins_type;
  logic [3:0]           r_ins_number;

  logic [1:0]           state_reg;
  logic [1:0]           state_next;
  logic [DW-1:0]        rdata_q;
  logic                 memop;

  reg_exe_mem #(
    .DW(DW)
  ) u_reg_exe_mem (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (~mem_stall),
    .exe_wreg       (exe_wreg),
    .exe_m2reg      (exe_m2reg),
    .exe_wmem       (exe_wmem),
    .exe_aluR       (exe_aluR),
    .exe_rb         (exe_rb),
    .exe_destR      (exe_destR),
    .exe_ins_type   (EXE_ins_type),
    .exe_ins_number (EXE_ins_number),
    .r_wreg         (r_wreg),
    .r_m2reg        (r_m2reg),
    .r_wmem         (r_wmem),
    .r_aluR         (r_aluR),
    .r_rb           (r_rb),
    .r_destR        (r_destR),
    .r_ins_type     (r_ins_type),
    .r_ins_number   (r_ins_number)
  );

  // A load+store combination is treated as a store (dmem_we follows r_wmem)
  assign memop = r_m2reg | r_wmem;

  // Handshake FSM: request/stall decode and next-state selection
  always_comb begin
    state_next = state_reg;
    dmem_req   = 1'b0;
    mem_stall  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        dmem_req = memop;
        if (memop && !dmem_ack) begin
          mem_stall  = 1'b1;
          state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        dmem_req  = 1'b1;
        mem_stall = 1'b1;
        if (dmem_ack) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // FSM state register; reset abandons any outstanding request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Hold the delayed read data so it can be presented in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (state_reg == ST_BUSY && dmem_ack) begin
      rdata_q <= dmem_rdata;
    end
  end

  // Memory port: all fields come straight from the held register, so they
  // stay stable for the whole request
  assign dmem_addr  = r_aluR[AW-1:0];
  assign dmem_wdata = r_rb;
  assign dmem_we    = r_wmem & dmem_req;

  // Load data: captured copy after a waited access, live bus on zero-wait;
  // forced to 0 while in reset so the stage presents all-zero outputs
  assign mem_mdata = !rst_n                  ? '0      :
                     (state_reg == ST_DONE)  ? rdata_q : dmem_rdata;

  // Bubble gating toward the enable-less MEM/WB register
  assign mem_wreg       = r_wreg & ~mem_stall;
  assign mem_m2reg      = r_m2reg & ~mem_stall;
  assign mem_aluR       = r_aluR;
  assign mem_destR      = r_destR;
  assign MEM_ins_type   = r_ins_type;
  assign MEM_ins_number = r_ins_number;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed bench for mem_stage_hs. Inputs change on the falling edge and
// outputs are checked 1 ns later, well away from the rising edge.
module tb_mem_stage_hs;
  import cpu_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic          exe_wreg;
  logic          exe_m2reg;
  logic          exe_wmem;
  logic [DW-1:0] exe_aluR;
  logic [DW-1:0] exe_rb;
  logic [4:0]    exe_destR;
  logic [3:0]    EXE_ins_type;
  logic [3:0]    EXE_ins_number;
  logic [DW-1:0] dmem_rdata;
  logic          dmem_ack;
  logic          dmem_req;
  logic          dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic          mem_wreg;
  logic          mem_m2reg;
  logic [DW-1:0] mem_aluR;
  logic [DW-1:0] mem_mdata;
  logic [4:0]    mem_destR;
  logic [3:0]    MEM_ins_type;
  logic [3:0]    MEM_ins_number;
  logic          mem_stall;

  int n_cmp = 0;
  int n_err = 0;

  mem_stage_hs #(.AW(AW), .DW(DW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .exe_wreg       (exe_wreg),
    .exe_m2reg      (exe_m2reg),
    .exe_wmem       (exe_wmem),
    .exe_aluR       (exe_aluR),
    .exe_rb         (exe_rb),
    .exe_destR      (exe_destR),
    .EXE_ins_type   (EXE_ins_type),
    .EXE_ins_number (EXE_ins_number),
    .dmem_rdata     (dmem_rdata),
    .dmem_ack       (dmem_ack),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .mem_wreg       (mem_wreg),
    .mem_m2reg      (mem_m2reg),
    .mem_aluR       (mem_aluR),
    .mem_mdata      (mem_mdata),
    .mem_destR      (mem_destR),
    .MEM_ins_type   (MEM_ins_type),
    .MEM_ins_number (MEM_ins_number),
    .mem_stall      (mem_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one instruction onto the EXE side
  task automatic set_exe(input logic wreg, input logic m2reg, input logic wmem,
                         input logic [DW-1:0] alu, input logic [DW-1:0] rb,
                         input logic [4:0] dest, input logic [3:0] typ,
                         input logic [3:0] num);
    exe_wreg = wreg; exe_m2reg = m2reg; exe_wmem = wmem;
    exe_aluR = alu; exe_rb = rb; exe_destR = dest;
    EXE_ins_type = typ; EXE_ins_number = num;
  endtask

  task automatic set_nop();
    set_exe(1'b0, 1'b0, 1'b0, '0, '0, 5'd0, INS_NOP, 4'd0);
  endtask

  // Advance to the next falling edge (inputs may then be changed)
  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_exe(1'b1, 1'b1, 1'b0, 32'h10, 32'h20, 5'd3, INS_LOAD, 4'd1);
    dmem_ack = 1'b0; dmem_rdata = 32'h5555_5555;
    to_neg(); #1;
    n_cmp++;
    if ({dmem_req, dmem_we, mem_stall, mem_wreg, mem_m2reg} !== 5'b0 ||
        mem_aluR !== 32'h0 || mem_mdata !== 32'h0 || mem_destR !== 5'd0 ||
        dmem_addr !== 32'h0 || MEM_ins_number !== 4'd0) begin
      n_err++;
      $display("FAIL reset_outputs: req=%b stall=%b wreg=%b aluR=%h mdata=%h destR=%0d, required all 0",
               dmem_req, mem_stall, mem_wreg, mem_aluR, mem_mdata, mem_destR);
    end
    $display("reset: req=%b stall=%b mdata=%h", dmem_req, mem_stall, mem_mdata);
    set_nop();
    rst_n = 1'b1;
    to_neg();
  endtask

  task automatic test_zero_wait_load();
    set_exe(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd5, INS_LOAD, 4'd2);
    to_neg();
    set_nop();
    dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    #1;
    n_cmp++;
    if (dmem_req !== 1'b1 || dmem_addr !== 32'h40 || mem_stall !== 1'b0 || dmem_we !== 1'b0) begin
      n_err++;
      $display("FAIL zw_port: req=%b addr=%h stall=%b we=%b, required 1 00000040 0 0",
               dmem_req, dmem_addr, mem_stall, dmem_we);
    end
    n_cmp++;
    if (mem_wreg !== 1'b1 || mem_m2reg !== 1'b1 || mem_mdata !== 32'hDEAD_BEEF ||
        mem_destR !== 5'd5 || MEM_ins_type !== INS_LOAD || MEM_ins_number !== 4'd2) begin
      n_err++;
      $display("FAIL zw_result: wreg=%b m2reg=%b mdata=%h destR=%0d type=%0d num=%0d, required 1 1 deadbeef 5 2 2",
               mem_wreg, mem_m2reg, mem_mdata, mem_destR, MEM_ins_type, MEM_ins_number);
    end
    $display("zero-wait load: addr=%h mdata=%h stall=%b", dmem_addr, mem_mdata, mem_stall);
    to_neg();
    dmem_ack = 1'b0;
    #1;
    n_cmp++;
    if (dmem_req !== 1'b0 || mem_wreg !== 1'b0 || mem_stall !== 1'b0) begin
      n_err++;
      $display("FAIL zw_followup_nop: req=%b wreg=%b stall=%b, required 0 0 0", dmem_req, mem_wreg, mem_stall);
    end
  endtask

  // Two-wait load followed directly by an ALU op that must wait for DONE
  task automatic test_wait_load_then_alu();
    int stall_cnt;
    set_exe(1'b1, 1'b1, 1'b0, 32'h44, 32'h0, 5'd7, INS_LOAD, 4'd3);
    to_neg();
    // ALU op presented during the stall must not be captured
    set_exe(1'b1, 1'b0, 1'b0, 32'h99, 32'h0, 5'd9, INS_ALU, 4'd4);
    dmem_ack = 1'b0; dmem_rdata = 32'hFFFF_0000;
    stall_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin
        dmem_ack = 1'b1; dmem_rdata = 32'h1234;
      end
      #1;
      if (mem_stall === 1'b1) stall_cnt++;
      n_cmp++;
      if (dmem_req !== 1'b1 || mem_stall !== 1'b1 || mem_wreg !== 1'b0 ||
          mem_m2reg !== 1'b0 || mem_destR !== 5'd7 || dmem_addr !== 32'h44) begin
        n_err++;
        $display("FAIL wl_stall_c%0d: req=%b stall=%b wreg=%b m2reg=%b destR=%0d addr=%h, required 1 1 0 0 7 00000044",
                 c, dmem_req, mem_stall, mem_wreg, mem_m2reg, mem_destR, dmem_addr);
      end
      $display("wait load cycle %0d: req=%b stall=%b wreg=%b", c, dmem_req, mem_stall, mem_wreg);
      to_neg();
    end
    dmem_ack = 1'b0; dmem_rdata = 32'hBAD0_BAD0;
    #1;
    n_cmp++;
    if (stall_cnt != 3) begin
      n_err++;
      $display("FAIL wl_stall_count: got %0d, required 3", stall_cnt);
    end
    n_cmp++;
    if (dmem_req !== 1'b0 || mem_stall !== 1'b0 || mem_wreg !== 1'b1 || mem_m2reg !== 1'b1 ||
        mem_mdata !== 32'h1234 || mem_destR !== 5'd7) begin
      n_err++;
      $display("FAIL wl_done: req=%b stall=%b wreg=%b m2reg=%b mdata=%h destR=%0d, required 0 0 1 1 00001234 7",
               dmem_req, mem_stall, mem_wreg, mem_m2reg, mem_mdata, mem_destR);
    end
    $display("wait load done: mdata=%h destR=%0d", mem_mdata, mem_destR);
    to_neg();
    set_nop();
    #1;
    n_cmp++;
    if (dmem_req !== 1'b0 || mem_stall !== 1'b0 || mem_wreg !== 1'b1 || mem_m2reg !== 1'b0 ||
        mem_aluR !== 32'h99 || mem_destR !== 5'd9 || MEM_ins_number !== 4'd4) begin
      n_err++;
      $display("FAIL alu_after_load: req=%b stall=%b wreg=%b m2reg=%b aluR=%h destR=%0d num=%0d, required 0 0 1 0 00000099 9 4",
               dmem_req, mem_stall, mem_wreg, mem_m2reg, mem_aluR, mem_destR, MEM_ins_number);
    end
    $display("alu after load: aluR=%h destR=%0d", mem_aluR, mem_destR);
    to_neg();
  endtask

  task automatic test_store();
    set_exe(1'b0, 1'b0, 1'b1, 32'h80, 32'hCAFE, 5'd0, INS_STORE, 4'd5);
    to_neg();
    set_nop();
    dmem_ack = 1'b0;
    for (int c = 0; c < 2; c++) begin
      if (c == 1) dmem_ack = 1'b1;
      #1;
      n_cmp++;
      if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'h80 ||
          dmem_wdata !== 32'hCAFE || mem_stall !== 1'b1 || mem_wreg !== 1'b0) begin
        n_err++;
        $display("FAIL st_hold_c%0d: req=%b we=%b addr=%h wdata=%h stall=%b wreg=%b, required 1 1 00000080 0000cafe 1 0",
                 c, dmem_req, dmem_we, dmem_addr, dmem_wdata, mem_stall, mem_wreg);
      end
      $display("store cycle %0d: we=%b addr=%h wdata=%h", c, dmem_we, dmem_addr, dmem_wdata);
      to_neg();
    end
    dmem_ack = 1'b0;
    #1;
    n_cmp++;
    if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || mem_stall !== 1'b0 || mem_wreg !== 1'b0) begin
      n_err++;
      $display("FAIL st_done: req=%b we=%b stall=%b wreg=%b, required 0 0 0 0",
               dmem_req, dmem_we, mem_stall, mem_wreg);
    end
    to_neg();
  endtask

  task automatic test_spurious_ack();
    dmem_ack = 1'b1;
    #1;
    n_cmp++;
    if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
      n_err++;
      $display("FAIL spurious_ack: req=%b stall=%b, required 0 0", dmem_req, mem_stall);
    end
    to_neg();
    dmem_ack = 1'b0;
    #1;
    n_cmp++;
    if (dmem_req !== 1'b0 || mem_stall !== 1'b0 || mem_wreg !== 1'b0) begin
      n_err++;
      $display("FAIL spurious_after: req=%b stall=%b wreg=%b, required 0 0 0", dmem_req, mem_stall, mem_wreg);
    end
    $display("spurious ack: req=%b stall=%b", dmem_req, mem_stall);
    to_neg();
  endtask

  task automatic test_reset_mid_busy();
    set_exe(1'b1, 1'b1, 1'b0, 32'h60, 32'h0, 5'd11, INS_LOAD, 4'd6);
    to_neg();
    set_nop();
    dmem_ack = 1'b0; dmem_rdata = 32'hAAAA_AAAA;
    to_neg();
    #1;
    n_cmp++;
    if (dmem_req !== 1'b1 || mem_stall !== 1'b1) begin
      n_err++;
      $display("FAIL rb_busy: req=%b stall=%b, required 1 1", dmem_req, mem_stall);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (dmem_req !== 1'b0 || mem_stall !== 1'b0 || mem_wreg !== 1'b0 || mem_m2reg !== 1'b0 ||
        mem_aluR !== 32'h0 || mem_mdata !== 32'h0 || mem_destR !== 5'd0 || dmem_addr !== 32'h0) begin
      n_err++;
      $display("FAIL rb_in_reset: req=%b stall=%b wreg=%b aluR=%h mdata=%h destR=%0d addr=%h, required all 0",
               dmem_req, mem_stall, mem_wreg, mem_aluR, mem_mdata, mem_destR, dmem_addr);
    end
    $display("reset mid-busy: req=%b stall=%b", dmem_req, mem_stall);
    to_neg();
    rst_n = 1'b1;
    to_neg();
    #1;
    n_cmp++;
    if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
      n_err++;
      $display("FAIL rb_after_release: req=%b stall=%b, required 0 0 (IDLE)", dmem_req, mem_stall);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait_load();
    test_wait_load_then_alu();
    test_store();
    test_spurious_ack();
    test_reset_mid_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
